mmio_io_bridge: RTL and testbench

- Memory-mapped I/O slave on the processor's data-memory port; decodes the high address space and drives DE1-SoC peripherals (LEDR, HEX0-5) and samples SW/KEY.
- Sits directly downstream of the pipelined core's data port, beside data RAM. The top level routes accesses with DataAddr[15:12] != 0 here.
- Owns the halt register at 16'hFFFF. It latches the processor's kill write into a sticky Halted flag for the top level and the bench.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/hex7seg.sv | 33 +++
 rtl/mmio_io_bridge.sv | 155 +++++++++++++++
 tb/tb_mmio_io_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped I/O bridge.
package mmio_pkg;

  localparam int unsigned SW_W    = 10;
  localparam int unsigned KEY_W   = 3;
  localparam int unsigned NUM_HEX = 6;

  localparam logic [15:0] ADDR_LEDR     = 16'h1000;
  localparam logic [15:0] ADDR_SW       = 16'h1001;
  localparam logic [15:0] ADDR_KEY      = 16'h1002;
  localparam logic [15:0] ADDR_KEYEDGE  = 16'h1003;
  localparam logic [15:0] ADDR_HEX_BASE = 16'h2000;
  localparam logic [15:0] ADDR_CNT_LO   = 16'h3000;
  localparam logic [15:0] ADDR_CNT_HI   = 16'h3001;
  localparam logic [15:0] ADDR_HALT     = 16'hFFFF;

  // One seven-segment digit register: blank overrides the digit.
  typedef struct packed {
    logic       blank;
    logic [3:0] digit;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{blank: 1'b1, digit: 4'h0};

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low seven-segment decoder (bit order g..a).
module hex7seg (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg_c
);

  // Segment pattern lookup; blank turns every segment off.
  always_comb begin
    seg_c = 7'h7F;
    if (!blank) begin
      case (digit)
        4'h0: seg_c = 7'h40;
        4'h1: seg_c = 7'h79;
        4'h2: seg_c = 7'h24;
        4'h3: seg_c = 7'h30;
        4'h4: seg_c = 7'h19;
        4'h5: seg_c = 7'h12;
        4'h6: seg_c = 7'h02;
        4'h7: seg_c = 7'h78;
        4'h8: seg_c = 7'h00;
        4'h9: seg_c = 7'h10;
        4'hA: seg_c = 7'h08;
        4'hB: seg_c = 7'h03;
        4'hC: seg_c = 7'h46;
        4'hD: seg_c = 7'h21;
        4'hE: seg_c = 7'h06;
        default: seg_c = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/mmio_io_bridge.sv
// MMIO slave: LED/HEX registers, switch/key sampling, cycle counter and halt flag.
module mmio_io_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic              WriteData,
  input  logic              ReadData,
  input  logic [DATA_W-1:0] DataOut,
  output logic [DATA_W-1:0] DataIn,
  input  logic [SW_W-1:0]   SW,
  input  logic [KEY_W-1:0]  KEY,
  output logic [SW_W-1:0]   LEDR,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic              Halted
);

  logic [SW_W-1:0]   ledr_q;
  digit_t            hex_q [NUM_HEX];
  logic              halted_q;
  logic [KEY_W-1:0]  cap_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] snap_q;
  logic [DATA_W-1:0] din_q;
  logic [SW_W-1:0]   sw_s1, sw_s2;
  logic [KEY_W-1:0]  key_s1, key_s2, key_prev;

  logic              wr_en;
  logic              hex_hit;
  logic [2:0]        hex_sel;
  logic [KEY_W-1:0]  key_rise;
  logic [KEY_W-1:0]  cap_clr;
  logic [DATA_W-1:0] rdata;
  logic [6:0]        seg [NUM_HEX];
  logic              unused_bits;

  // Once halted, only the halt register still accepts writes.
  assign wr_en    = WriteData && (!halted_q || (DataAddr == ADDR_HALT));
  assign hex_sel  = DataAddr[2:0];
  assign hex_hit  = (DataAddr[ADDR_W-1:3] == ADDR_HEX_BASE[15:3]) && (hex_sel < 3'(NUM_HEX));
  assign key_rise = key_s2 & ~key_prev;
  assign cap_clr  = (wr_en && (DataAddr == ADDR_KEYEDGE)) ? DataOut[KEY_W-1:0] : '0;
  assign unused_bits = ^DataOut[DATA_W-1:SW_W];

  // Read mux over the current (pre-write) register state.
  always_comb begin
    rdata = '0;
    if (hex_hit) begin
      rdata = DATA_W'(hex_q[hex_sel]);
    end else begin
      case (DataAddr)
        ADDR_LEDR:    rdata = DATA_W'(ledr_q);
        ADDR_SW:      rdata = DATA_W'(sw_s2);
        ADDR_KEY:     rdata = DATA_W'(key_s2);
        ADDR_KEYEDGE: rdata = DATA_W'(cap_q);
        ADDR_CNT_LO:  rdata = cnt_q[DATA_W-1:0];
        ADDR_CNT_HI:  rdata = snap_q;
        ADDR_HALT:    rdata = DATA_W'(halted_q);
        default:      rdata = '0;
      endcase
    end
  end

  // Two-flop synchronizers; keys are inverted so 1 means pressed.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
    end else begin
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      key_s1   <= ~KEY;
      key_s2   <= key_s1;
      key_prev <= key_s2;
    end
  end

  // Key edge capture: a new press beats a same-cycle clear.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cap_q <= '0;
    end else begin
      cap_q <= (cap_q & ~cap_clr) | key_rise;
    end
  end

  // Free-running counter and high-half snapshot taken on CNT_LO reads.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (ReadData && (DataAddr == ADDR_CNT_LO)) begin
        snap_q <= DATA_W'(cnt_q >> DATA_W);
      end
    end
  end

  // Writable registers: LEDs, digits and the sticky halt flag.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      ledr_q   <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= DIGIT_RESET;
    end else begin
      if (wr_en && (DataAddr == ADDR_LEDR)) ledr_q <= DataOut[SW_W-1:0];
      if (wr_en && (DataAddr == ADDR_HALT)) halted_q <= 1'b1;
      for (int i = 0; i < NUM_HEX; i++) begin
        if (wr_en && hex_hit && (hex_sel == 3'(i))) hex_q[i] <= digit_t'(DataOut[4:0]);
      end
    end
  end

  // Registered read return, held while no read is strobed.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      din_q <= '0;
    end else if (ReadData) begin
      din_q <= rdata;
    end
  end

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
    hex7seg u_hex7seg (
      .digit (hex_q[g].digit),
      .blank (hex_q[g].blank),
      .seg_c (seg[g])
    );
  end

  assign DataIn = din_q;
  assign LEDR   = ledr_q;
  assign Halted = halted_q;
  assign HEX0   = seg[0];
  assign HEX1   = seg[1];
  assign HEX2   = seg[2];
  assign HEX3   = seg[3];
  assign HEX4   = seg[4];
  assign HEX5   = seg[5];

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed plus randomized bench for mmio_io_bridge against a register-map model.
module tb_mmio_io_bridge;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [15:0] DataAddr;
  logic        WriteData;
  logic        ReadData;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  logic [9:0]  SW;
  logic [2:0]  KEY;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        Halted;

  int checks = 0;
  int failures = 0;

  // Reference state of the register map.
  logic [31:0] m_cnt;
  logic [9:0]  m_ledr;
  logic [4:0]  m_hex [6];
  logic        m_halted;
  logic [2:0]  m_cap;
  logic [15:0] m_snap;
  logic [15:0] m_din;

  mmio_io_bridge dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .DataAddr  (DataAddr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .DataOut   (DataOut),
    .DataIn    (DataIn),
    .SW        (SW),
    .KEY       (KEY),
    .LEDR      (LEDR),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5),
    .Halted    (Halted)
  );

  always #5 Clock = ~Clock;

  // Cycles elapsed since reset release.
  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) m_cnt <= 32'h0;
    else         m_cnt <= m_cnt + 32'h1;
  end

  function automatic logic [6:0] seg_of(logic [4:0] r);
    logic [6:0] on [16];
    on = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    if (r[4]) return 7'h7F;
    return ~on[r[3:0]];
  endfunction

  function automatic logic [15:0] model_read(logic [15:0] a);
    if (a == 16'h1000) return {6'b0, m_ledr};
    if (a == 16'h1001) return {6'b0, SW};
    if (a == 16'h1002) return {13'b0, ~KEY};
    if (a == 16'h1003) return {13'b0, m_cap};
    if (a >= 16'h2000 && a <= 16'h2005) return {11'b0, m_hex[int'(a[2:0])]};
    if (a == 16'h3000) return m_cnt[15:0];
    if (a == 16'h3001) return m_snap;
    if (a == 16'hFFFF) return {15'b0, m_halted};
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_ledr = 10'h0;
    for (int i = 0; i < 6; i++) m_hex[i] = 5'h10;
    m_halted = 1'b0;
    m_cap = 3'b0;
    m_snap = 16'h0;
    m_din = 16'h0;
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    logic [6:0] hx [6];
    hx = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
    chk("ledr", {6'b0, LEDR}, {6'b0, m_ledr});
    for (int i = 0; i < 6; i++) chk($sformatf("hex%0d", i), {9'b0, hx[i]}, {9'b0, seg_of(m_hex[i])});
    chk("halted", {15'b0, Halted}, {15'b0, m_halted});
    chk("datain", DataIn, m_din);
  endtask

  // One bus cycle, entered and left at a negedge; outputs checked afterwards.
  task automatic cycle(bit we, bit re, logic [15:0] a, logic [15:0] d);
    logic [15:0] rv;
    WriteData = we;
    ReadData  = re;
    DataAddr  = a;
    DataOut   = d;
    rv = model_read(a);
    if (re) m_din = rv;
    if (re && a == 16'h3000) m_snap = m_cnt[31:16];
    if (we && (!m_halted || a == 16'hFFFF)) begin
      if (a == 16'h1000) m_ledr = d[9:0];
      if (a >= 16'h2000 && a <= 16'h2005) m_hex[int'(a[2:0])] = d[4:0];
      if (a == 16'h1003) m_cap = m_cap & ~d[2:0];
      if (a == 16'hFFFF) m_halted = 1'b1;
    end
    @(posedge Clock);
    #1;
    WriteData = 1'b0;
    ReadData  = 1'b0;
    @(negedge Clock);
    check_outs();
  endtask

  initial begin
    logic [15:0] addrs [15];
    int n;
    addrs = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h2000, 16'h2001, 16'h2002, 16'h2003,
              16'h2004, 16'h2005, 16'h3000, 16'h3001, 16'h1004, 16'h2006, 16'h8000};

    ResetN = 1'b0;
    WriteData = 1'b0;
    ReadData = 1'b0;
    DataAddr = 16'h0;
    DataOut = 16'h0;
    SW = 10'h2C3;
    KEY = 3'b111;
    model_reset();
    repeat (3) @(negedge Clock);
    check_outs();
    chk("reset_hex5", {9'b0, HEX5}, 16'h007F);
    ResetN = 1'b1;

    // Coherent counter pair across the 16-bit carry.
    n = 0;
    while (m_cnt[15:0] != 16'hFFFF && n < 70000) begin
      @(negedge Clock);
      n++;
    end
    chk("cnt_budget", {15'b0, n < 70000}, 16'h0001);
    cycle(0, 1, 16'h3000, 16'h0);
    chk("cnt_lo", DataIn, 16'hFFFF);
    cycle(0, 1, 16'h3001, 16'h0);
    chk("cnt_hi_snap", DataIn, 16'h0000);

    // LED write/read and HEX digit/blank.
    cycle(1, 0, 16'h1000, 16'h02A5);
    chk("ledr_2a5", {6'b0, LEDR}, 16'h02A5);
    cycle(0, 1, 16'h1000, 16'h0);
    chk("read_ledr", DataIn, 16'h02A5);
    cycle(1, 0, 16'h2003, 16'h0008);
    cycle(1, 0, 16'h2000, 16'h0013);
    chk("hex3_eight", {9'b0, HEX3}, 16'h0000);
    chk("hex0_blank", {9'b0, HEX0}, 16'h007F);
    cycle(0, 1, 16'h1001, 16'h0);
    chk("read_sw", DataIn, 16'h02C3);
    cycle(1, 1, 16'h1000, 16'h0155);
    chk("rbw_old", DataIn, 16'h02A5);
    chk("rbw_new", {6'b0, LEDR}, 16'h0155);
    cycle(0, 1, 16'h8000, 16'h0);

    // Randomized accesses over mapped and unmapped addresses.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            addrs[$urandom_range(0, 14)], 16'($urandom));
    end

    // Key press capture and W1C clear.
    KEY = 3'b101;
    m_cap[1] = 1'b1;
    repeat (4) cycle(0, 0, 16'h0, 16'h0);
    cycle(0, 1, 16'h1002, 16'h0);
    chk("key_level", DataIn, 16'h0002);
    KEY = 3'b111;
    repeat (3) cycle(0, 0, 16'h0, 16'h0);
    cycle(0, 1, 16'h1003, 16'h0);
    chk("key_edge", DataIn, 16'h0002);
    cycle(1, 0, 16'h1003, 16'h0002);
    cycle(0, 1, 16'h1003, 16'h0);
    chk("key_w1c", DataIn, 16'h0000);

    // Press landing on the same edge as a clear keeps the bit.
    KEY = 3'b101;
    cycle(0, 0, 16'h0, 16'h0);
    cycle(0, 0, 16'h0, 16'h0);
    cycle(1, 0, 16'h1003, 16'h0002);
    m_cap[1] = 1'b1;
    KEY = 3'b111;
    repeat (3) cycle(0, 0, 16'h0, 16'h0);
    cycle(0, 1, 16'h1003, 16'h0);
    chk("key_press_wins", DataIn, 16'h0002);

    // Halt and write lockout.
    cycle(1, 0, 16'hFFFF, 16'h0);
    chk("halt_set", {15'b0, Halted}, 16'h0001);
    cycle(1, 0, 16'h1000, 16'h03FF);
    chk("halt_lock_ledr", {6'b0, LEDR}, {6'b0, m_ledr});
    cycle(1, 0, 16'h2001, 16'h0005);
    cycle(0, 1, 16'hFFFF, 16'h0);
    chk("halt_read", DataIn, 16'h0001);
    cycle(0, 1, 16'h1000, 16'h0);

    // Asynchronous reset during a read.
    DataAddr = 16'h1000;
    ReadData = 1'b1;
    #2;
    ResetN = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("async_halt_clr", {15'b0, Halted}, 16'h0000);
    ReadData = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
    cycle(0, 1, 16'hFFFF, 16'h0);
    cycle(0, 1, 16'h2000, 16'h0);
    chk("post_reset_hex", DataIn, 16'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
